// File: rtl/pe_relay_pipe_if.sv
// Bundle of control, data and status signals for one pe_relay_pipe tile.
// master drives the tile's inputs; slave is the tile itself.
interface pe_relay_pipe_if #(
   parameter int WEST_WIDTH  = 162,
   parameter int NORTH_WIDTH = 424,
   parameter int SOUTH_WIDTH = 324,
   parameter int EAST_WIDTH  = 130,
   parameter int CNT_WIDTH   = 32
);
   logic                   ap_start;
   logic                   flush;
   logic [WEST_WIDTH-1:0]  in_from_west;
   logic [NORTH_WIDTH-1:0] in_from_north;
   logic [SOUTH_WIDTH-1:0] in_from_south;
   logic [EAST_WIDTH-1:0]  in_from_east;
   logic [WEST_WIDTH-1:0]  out_to_west;
   logic [NORTH_WIDTH-1:0] out_to_north;
   logic [SOUTH_WIDTH-1:0] out_to_south;
   logic [EAST_WIDTH-1:0]  out_to_east;
   logic [3:0]             out_valid;
   logic                   primed;
   logic [CNT_WIDTH-1:0]   adv_count;

   modport master (
      output ap_start, flush, in_from_west, in_from_north, in_from_south, in_from_east,
      input  out_to_west, out_to_north, out_to_south, out_to_east, out_valid, primed, adv_count
   );

   modport slave (
      input  ap_start, flush, in_from_west, in_from_north, in_from_south, in_from_east,
      output out_to_west, out_to_north, out_to_south, out_to_east, out_valid, primed, adv_count
   );
endinterface

// File: rtl/pe_relay_pipe.sv
// Four-direction relay tile for empty grid slots: each enabled channel is a
// PIPE_DEPTH-stage register pipeline with valid tracking, flush and fill status.

module pe_relay_lane #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);
   logic [WIDTH-1:0] data_r [DEPTH];
   logic [DEPTH-1:0] vld_r;

   // Shift register with valid; flush clears every stage and blocks sampling.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= '0;
         end
         vld_r <= '0;
      end else if (advance) begin
         data_r[0] <= din;
         vld_r[0]  <= 1'b1;
         for (int i = 1; i < DEPTH; i++) begin
            data_r[i] <= data_r[i-1];
            vld_r[i]  <= vld_r[i-1];
         end
      end
   end

   assign dout  = data_r[DEPTH-1];
   assign valid = vld_r[DEPTH-1];
endmodule

module pe_relay_pipe #(
   parameter int         WEST_WIDTH  = 162,
   parameter int         NORTH_WIDTH = 424,
   parameter int         SOUTH_WIDTH = 324,
   parameter int         EAST_WIDTH  = 130,
   parameter int         PIPE_DEPTH  = 2,
   parameter logic [3:0] CH_MASK     = 4'b1111,
   parameter int         CNT_WIDTH   = 32
) (
   input  logic              clk,
   input  logic              reset,
   pe_relay_pipe_if.slave    bus
);
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_PRIMED  = 2'd2
   } fill_state_t;

   fill_state_t          state_r, state_s;
   logic [3:0]           fill_r, fill_s;
   logic                 primed_r;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [3:0]           valid_s;
   logic                 advance_s;

   assign advance_s = bus.ap_start & ~bus.flush;

   if (CH_MASK[0]) begin : g_west
      pe_relay_lane #(.WIDTH(WEST_WIDTH), .DEPTH(PIPE_DEPTH)) u_lane (
         .clk(clk), .reset(reset), .advance(advance_s), .flush(bus.flush),
         .din(bus.in_from_west), .dout(bus.out_to_west), .valid(valid_s[0]));
   end else begin : g_west_off
      assign bus.out_to_west = '0;
      assign valid_s[0]      = 1'b0;
   end

   if (CH_MASK[1]) begin : g_north
      pe_relay_lane #(.WIDTH(NORTH_WIDTH), .DEPTH(PIPE_DEPTH)) u_lane (
         .clk(clk), .reset(reset), .advance(advance_s), .flush(bus.flush),
         .din(bus.in_from_north), .dout(bus.out_to_north), .valid(valid_s[1]));
   end else begin : g_north_off
      assign bus.out_to_north = '0;
      assign valid_s[1]       = 1'b0;
   end

   if (CH_MASK[2]) begin : g_south
      pe_relay_lane #(.WIDTH(SOUTH_WIDTH), .DEPTH(PIPE_DEPTH)) u_lane (
         .clk(clk), .reset(reset), .advance(advance_s), .flush(bus.flush),
         .din(bus.in_from_south), .dout(bus.out_to_south), .valid(valid_s[2]));
   end else begin : g_south_off
      assign bus.out_to_south = '0;
      assign valid_s[2]       = 1'b0;
   end

   if (CH_MASK[3]) begin : g_east
      pe_relay_lane #(.WIDTH(EAST_WIDTH), .DEPTH(PIPE_DEPTH)) u_lane (
         .clk(clk), .reset(reset), .advance(advance_s), .flush(bus.flush),
         .din(bus.in_from_east), .dout(bus.out_to_east), .valid(valid_s[3]));
   end else begin : g_east_off
      assign bus.out_to_east = '0;
      assign valid_s[3]      = 1'b0;
   end

   // Fill-state next-state logic; fill_r counts advances until the last stage fills.
   always_comb begin
      state_s = state_r;
      fill_s  = fill_r;
      case (state_r)
         ST_EMPTY: begin
            if (advance_s && (CH_MASK != 4'b0000)) begin
               fill_s  = 4'd1;
               state_s = (PIPE_DEPTH == 1) ? ST_PRIMED : ST_FILLING;
            end else begin
               fill_s  = 4'd0;
            end
         end
         ST_FILLING: begin
            if (advance_s) begin
               fill_s = fill_r + 4'd1;
               if (fill_s == 4'(PIPE_DEPTH)) begin
                  state_s = ST_PRIMED;
               end else begin
                  state_s = ST_FILLING;
               end
            end else begin
               state_s = ST_FILLING;
            end
         end
         ST_PRIMED: begin
            state_s = ST_PRIMED;
         end
         default: begin
            state_s = ST_EMPTY;
            fill_s  = 4'd0;
         end
      endcase
   end

   // Fill-state register; primed is registered from the next state.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         state_r  <= ST_EMPTY;
         fill_r   <= 4'd0;
         primed_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         fill_r   <= fill_s;
         primed_r <= (state_s == ST_PRIMED);
      end
   end

   // Saturating count of advance cycles since reset or flush.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         cnt_r <= '0;
      end else if (advance_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
         cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
   end

   assign bus.out_valid = valid_s;
   assign bus.primed    = primed_r;
   assign bus.adv_count = cnt_r;
endmodule

// File: tb/tb_pe_relay_pipe.sv
// Directed bench for pe_relay_pipe: default tile, a W/S-only tile and a
// depth-1 tile with a 4-bit advance counter.
module tb_pe_relay_pipe;
   logic clk = 1'b0;
   logic reset;
   int   checks_cnt = 0;
   int   errors_cnt = 0;

   always #5 clk = ~clk;

   pe_relay_pipe_if if_a();
   pe_relay_pipe_if if_b();
   pe_relay_pipe_if #(.WEST_WIDTH(8), .NORTH_WIDTH(8), .SOUTH_WIDTH(8), .EAST_WIDTH(8),
                      .CNT_WIDTH(4)) if_c();

   pe_relay_pipe u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
   pe_relay_pipe #(.CH_MASK(4'b0101)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
   pe_relay_pipe #(.WEST_WIDTH(8), .NORTH_WIDTH(8), .SOUTH_WIDTH(8), .EAST_WIDTH(8),
                   .PIPE_DEPTH(1), .CNT_WIDTH(4)) u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

   task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with every input high and ap_start asserted
      reset = 1'b1;
      if_a.ap_start = 1'b1; if_a.flush = 1'b0;
      if_a.in_from_west = '1; if_a.in_from_north = '1; if_a.in_from_south = '1; if_a.in_from_east = '1;
      if_b.ap_start = 1'b1; if_b.flush = 1'b0;
      if_b.in_from_west = '1; if_b.in_from_north = '1; if_b.in_from_south = '1; if_b.in_from_east = '1;
      if_c.ap_start = 1'b1; if_c.flush = 1'b0;
      if_c.in_from_west = '1; if_c.in_from_north = '1; if_c.in_from_south = '1; if_c.in_from_east = '1;
      tick();
      tick();
      check_val("rst_west",  512'(if_a.out_to_west),  512'h0);
      check_val("rst_north", 512'(if_a.out_to_north), 512'h0);
      check_val("rst_south", 512'(if_a.out_to_south), 512'h0);
      check_val("rst_east",  512'(if_a.out_to_east),  512'h0);
      check_val("rst_valid", 512'(if_a.out_valid),    512'h0);
      check_val("rst_primed", 512'(if_a.primed),      512'h0);
      check_val("rst_cnt",   512'(if_a.adv_count),    512'h0);
      check_val("rst_cnt_b", 512'(if_b.adv_count),    512'h0);
      check_val("rst_cnt_c", 512'(if_c.adv_count),    512'h0);

      reset = 1'b0;
      if_a.ap_start = 1'b0; if_b.ap_start = 1'b0; if_c.ap_start = 1'b0;
      if_a.in_from_west = '0; if_a.in_from_north = '0; if_a.in_from_south = '0; if_a.in_from_east = '0;
      if_b.in_from_west = '0; if_b.in_from_north = '0; if_b.in_from_south = '0; if_b.in_from_east = '0;
      if_c.in_from_west = '0; if_c.in_from_north = '0; if_c.in_from_south = '0; if_c.in_from_east = '0;
      tick();
      check_val("idle_cnt", 512'(if_a.adv_count), 512'h0);

      // stall: ap_start 1,0,0,1 with west 0xA then 0xB during the stall
      if_a.ap_start = 1'b1; if_a.in_from_west = 162'hA;
      tick();
      check_val("stall_out0", 512'(if_a.out_to_west), 512'h0);
      check_val("stall_cnt0", 512'(if_a.adv_count),   512'h1);
      if_a.ap_start = 1'b0; if_a.in_from_west = 162'hB;
      tick();
      check_val("stall_out1", 512'(if_a.out_to_west), 512'h0);
      tick();
      check_val("stall_cnt2", 512'(if_a.adv_count),   512'h1);
      check_val("stall_prm2", 512'(if_a.primed),      512'h0);
      if_a.ap_start = 1'b1; if_a.in_from_west = 162'hC;
      tick();
      check_val("stall_out3", 512'(if_a.out_to_west), 512'hA);
      check_val("stall_cnt3", 512'(if_a.adv_count),   512'h2);
      check_val("stall_vld3", 512'(if_a.out_valid),   512'hF);
      check_val("stall_prm3", 512'(if_a.primed),      512'h1);
      if_a.in_from_west = 162'hD;
      tick();
      check_val("stall_out4", 512'(if_a.out_to_west), 512'hC);
      check_val("stall_cnt4", 512'(if_a.adv_count),   512'h3);

      // flush with ap_start while primed; inputs on that cycle must not be captured
      if_a.flush = 1'b1; if_a.in_from_west = 162'h55; if_a.in_from_north = 424'hFF;
      tick();
      check_val("fl_west",   512'(if_a.out_to_west),  512'h0);
      check_val("fl_north",  512'(if_a.out_to_north), 512'h0);
      check_val("fl_valid",  512'(if_a.out_valid),    512'h0);
      check_val("fl_primed", 512'(if_a.primed),       512'h0);
      check_val("fl_cnt",    512'(if_a.adv_count),    512'h0);

      // north words 1,2,3 on consecutive advances after the flush
      if_a.flush = 1'b0; if_a.in_from_west = 162'h66; if_a.in_from_north = 424'h1;
      tick();
      check_val("n_out1",  512'(if_a.out_to_north), 512'h0);
      check_val("n_vld1",  512'(if_a.out_valid),    512'h0);
      check_val("n_prm1",  512'(if_a.primed),       512'h0);
      if_a.in_from_west = 162'h77; if_a.in_from_north = 424'h2;
      tick();
      check_val("n_out2",  512'(if_a.out_to_north), 512'h1);
      check_val("n_west2", 512'(if_a.out_to_west),  512'h66);
      check_val("n_vld2",  512'(if_a.out_valid),    512'hF);
      check_val("n_prm2",  512'(if_a.primed),       512'h1);
      check_val("n_cnt2",  512'(if_a.adv_count),    512'h2);
      if_a.in_from_north = 424'h3;
      tick();
      check_val("n_out3",  512'(if_a.out_to_north), 512'h2);
      if_a.in_from_north = 424'h0;
      tick();
      check_val("n_out4",  512'(if_a.out_to_north), 512'h3);
      check_val("n_cnt4",  512'(if_a.adv_count),    512'h4);
      if_a.ap_start = 1'b0;

      // W/S-only tile: N and E stay zero, primed follows W and S
      if_b.ap_start = 1'b1;
      if_b.in_from_west = 162'h11; if_b.in_from_north = 424'h22;
      if_b.in_from_south = 324'h33; if_b.in_from_east = 130'h44;
      tick();
      check_val("m_north1", 512'(if_b.out_to_north), 512'h0);
      check_val("m_prm1",   512'(if_b.primed),        512'h0);
      tick();
      check_val("m_west2",  512'(if_b.out_to_west),  512'h11);
      check_val("m_south2", 512'(if_b.out_to_south), 512'h33);
      check_val("m_north2", 512'(if_b.out_to_north), 512'h0);
      check_val("m_east2",  512'(if_b.out_to_east),  512'h0);
      check_val("m_vld2",   512'(if_b.out_valid),    512'h5);
      check_val("m_prm2",   512'(if_b.primed),       512'h1);
      if_b.ap_start = 1'b0;

      // depth-1 tile with a 4-bit counter: 20 advances saturate at 15
      if_c.ap_start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if_c.in_from_west = 8'(i + 1);
         tick();
         if (i == 0) begin
            check_val("d1_out",  512'(if_c.out_to_west), 512'h1);
            check_val("d1_prm",  512'(if_c.primed),      512'h1);
            check_val("d1_vld",  512'(if_c.out_valid),   512'hF);
         end
         if (i == 14) begin
            check_val("sat_cnt15", 512'(if_c.adv_count), 512'hF);
         end
      end
      check_val("sat_cnt20", 512'(if_c.adv_count),   512'hF);
      check_val("d1_out20",  512'(if_c.out_to_west), 512'h14);
      if_c.ap_start = 1'b0; if_c.in_from_west = 8'hEE;
      tick();
      check_val("sat_hold",  512'(if_c.adv_count),   512'hF);
      check_val("d1_hold",   512'(if_c.out_to_west), 512'h14);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end
endmodule
